// File: rtl/spm_seq_wrap.sv
// Signed serial/parallel multiplier. x is held in parallel and y is streamed LSB-first
// through a carry-save array, producing one product bit per cycle over 2*WIDTH cycles.
module spm_seq_wrap #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               p_valid,
   input  logic               p_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int CNT_W = $clog2(2*WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*WIDTH-1);
   localparam logic [CNT_W-1:0] CNT_SIGN = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_x;
   logic [WIDTH-1:0]     r_y;
   logic [WIDTH-1:0]     r_sum;
   logic [WIDTH-1:0]     r_carry;
   logic [2*WIDTH-1:0]   r_p;

   logic                 w_ybit;
   logic                 w_last;
   logic                 w_accept;
   logic [WIDTH-1:0]     w_pp;
   logic [WIDTH-1:0]     w_sin;
   logic [WIDTH-1:0]     w_sum;
   logic [WIDTH-1:0]     w_carry;

   assign w_last   = (r_cnt == CNT_LAST);
   assign w_accept = in_valid && (r_state == S_IDLE);
   assign p        = r_p;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      p_valid     = 1'b0;
      busy        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            p_valid = 1'b1;
            if (p_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // After the first WIDTH cycles the multiplier stream continues with its sign bit.
   always_comb begin
      w_ybit = r_y[WIDTH-1];
      if (r_cnt < CNT_SIGN) w_ybit = r_y[r_cnt[CNT_W-2:0]];
   end

   // Cells 0..WIDTH-2 are serial full adders fed by the registered sum of the cell above.
   // The top cell is a serial subtractor (0 - pp) with a borrow flop, so the x sign bit
   // enters the array with negative weight.
   always_comb begin
      w_pp    = r_x & {WIDTH{w_ybit}};
      w_sin   = {1'b0, r_sum[WIDTH-1:1]};
      w_sum   = w_pp ^ w_sin ^ r_carry;
      w_carry = (w_pp & w_sin) | (w_pp & r_carry) | (w_sin & r_carry);
      w_carry[WIDTH-1] = w_pp[WIDTH-1] | r_carry[WIDTH-1];
   end

   // NOTE: sequential state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_sum   <= '0;
         r_carry <= '0;
         r_p     <= '0;
      end else begin
         if (w_accept) begin
            r_x     <= x;
            r_y     <= y;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= '0;
            r_p     <= '0;
         end else if (r_state == S_RUN) begin
            r_sum      <= w_sum;
            r_carry    <= w_carry;
            r_p[r_cnt] <= w_sum[0];
            r_cnt      <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spm_seq_wrap.sv
// Scoreboarded bench for spm_seq_wrap: a WIDTH=8 instance for protocol and corner cases,
// and a bank of WIDTH=32 instances run in lockstep for the random signed sweep.
module tb_spm_seq_wrap;

   localparam int NL      = 16;
   localparam int ROUNDS  = 625;
   localparam int NCORNER = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid8, in_ready8, p_valid8, p_ready8, busy8;
   logic [7:0]  x8, y8;
   logic [15:0] p8;

   logic          in_valid32, p_ready32;
   logic [NL-1:0] in_ready32, p_valid32, busy32;
   logic [31:0]   x32 [NL];
   logic [31:0]   y32 [NL];
   logic [63:0]   p32 [NL];

   logic [15:0] sb8  [$];
   logic [63:0] sb32 [$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  sx_tab [6] = '{8'hFF, 8'h80, 8'h7F, 8'h80, 8'h00, 8'h03};
   logic [7:0]  sy_tab [6] = '{8'h02, 8'h80, 8'h80, 8'h7F, 8'h55, 8'hFB};
   logic [15:0] sp_tab [6] = '{16'hFFFE, 16'h4000, 16'hC080, 16'hC080, 16'h0000, 16'hFFF1};
   logic [31:0] cx_tab [NCORNER] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
                                     32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
   logic [31:0] cy_tab [NCORNER] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                                     32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};

   spm_seq_wrap #(.WIDTH(8)) u_dut8 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid8),
      .in_ready (in_ready8),
      .x        (x8),
      .y        (y8),
      .p_valid  (p_valid8),
      .p_ready  (p_ready8),
      .p        (p8),
      .busy     (busy8)
   );

   for (genvar g = 0; g < NL; g++) begin : g_lane
      spm_seq_wrap #(.WIDTH(32)) u_dut32 (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid32),
         .in_ready (in_ready32[g]),
         .x        (x32[g]),
         .y        (y32[g]),
         .p_valid  (p_valid32[g]),
         .p_ready  (p_ready32),
         .p        (p32[g]),
         .busy     (busy32[g])
      );
   end

   function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 16'(sa * sb);
   endfunction

   function automatic logic [63:0] mul32(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return sa * sb;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_p8(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         if (p_valid8) ok = 1'b1;
         else step();
      end
   endtask

   task automatic launch8(input logic [7:0] a, input logic [7:0] b, output bit ok);
      x8 = a;
      y8 = b;
      in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      x8 = ~a;
      y8 = b ^ 8'h3C;
      wait_p8(60, ok);
   endtask

   task automatic handshake8();
      p_ready8 = 1'b1;
      step();
      p_ready8 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid8 = 1'b0; p_ready8 = 1'b0; x8 = '0; y8 = '0;
      in_valid32 = 1'b0; p_ready32 = 1'b0;
      for (int l = 0; l < NL; l++) begin
         x32[l] = '0;
         y32[l] = '0;
      end
      step(); step(); step();
      n_tests++;
      if (in_ready8 !== 1'b1 || p_valid8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_w8: in_ready=%b p_valid=%b busy=%b p=%h, required 1 0 0 0000",
                  in_ready8, p_valid8, busy8, p8);
      end
      n_tests++;
      if (in_ready32 !== '1 || p_valid32 !== '0 || busy32 !== '0 || p32[0] !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_w32: in_ready=%h p_valid=%h busy=%h p0=%h, required ffff 0000 0000 0",
                  in_ready32, p_valid32, busy32, p32[0]);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int n_edge, busy_cnt, rdy_seen;
      x8 = 8'd3;
      y8 = 8'd5;
      in_valid8 = 1'b1;
      sb8.push_back(16'h000F);
      step();
      in_valid8 = 1'b0;
      x8 = 8'hA5;
      y8 = 8'h5A;
      n_tests++;
      if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
         n_fail++;
         $display("FAIL first_accept: busy=%b in_ready=%b, required 1 0", busy8, in_ready8);
      end
      n_edge = 1; busy_cnt = 0; rdy_seen = 0;
      while (n_edge <= 100 && !p_valid8) begin
         if (busy8) busy_cnt++;
         if (in_ready8) rdy_seen++;
         step();
         n_edge++;
      end
      n_tests++;
      if (n_edge !== 17) begin
         n_fail++;
         $display("FAIL latency: p_valid seen at edge %0d, required 17", n_edge);
      end
      n_tests++;
      if (busy_cnt !== 16 || rdy_seen !== 0) begin
         n_fail++;
         $display("FAIL busy_cycles: busy=%0d in_ready_cycles=%0d, required 16 0", busy_cnt, rdy_seen);
      end
      n_tests++;
      if (p8 !== sb8[0]) begin
         n_fail++;
         $display("FAIL basic_product: p=%h, required %h", p8, sb8[0]);
      end
      void'(sb8.pop_front());
      handshake8();
      n_tests++;
      if (in_ready8 !== 1'b1 || p_valid8 !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_release: in_ready=%b p_valid=%b, required 1 0", in_ready8, p_valid8);
      end
   endtask

   task automatic test_signs();
      bit ok;
      logic [15:0] exp;
      for (int i = 0; i < 6; i++) begin
         sb8.push_back(sp_tab[i]);
         launch8(sx_tab[i], sy_tab[i], ok);
         exp = sb8.pop_front();
         n_tests++;
         if (!ok || p8 !== exp) begin
            n_fail++;
            $display("FAIL signed_%0d: x=%h y=%h p=%h valid=%b, required %h", i, sx_tab[i], sy_tab[i], p8, ok, exp);
         end
         handshake8();
      end
   endtask

   task automatic test_hold();
      bit ok;
      logic [15:0] exp;
      sb8.push_back(16'h03A8);
      launch8(8'h12, 8'h34, ok);
      exp = sb8.pop_front();
      for (int c = 0; c < 10; c++) begin
         in_valid8 = 1'b1;
         x8 = 8'($urandom);
         y8 = 8'($urandom);
         n_tests++;
         if (!ok || p_valid8 !== 1'b1 || in_ready8 !== 1'b0 || p8 !== exp) begin
            n_fail++;
            $display("FAIL hold_%0d: p_valid=%b in_ready=%b p=%h, required 1 0 %h", c, p_valid8, in_ready8, p8, exp);
         end
         step();
      end
      in_valid8 = 1'b0;
      handshake8();
      n_tests++;
      if (in_ready8 !== 1'b1 || p_valid8 !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: in_ready=%b p_valid=%b, required 1 0", in_ready8, p_valid8);
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      logic [15:0] exp;
      x8 = 8'h55;
      y8 = 8'h66;
      in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      for (int c = 0; c < 7; c++) step();
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (in_ready8 !== 1'b1 || p_valid8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
         n_fail++;
         $display("FAIL abort_immediate: in_ready=%b p_valid=%b busy=%b p=%h, required 1 0 0 0000",
                  in_ready8, p_valid8, busy8, p8);
      end
      step();
      n_tests++;
      if (in_ready8 !== 1'b1 || p_valid8 !== 1'b0 || p8 !== 16'h0) begin
         n_fail++;
         $display("FAIL abort_held: in_ready=%b p_valid=%b p=%h, required 1 0 0000", in_ready8, p_valid8, p8);
      end
      rst = 1'b0;
      sb8.push_back(16'hFFFA);
      launch8(8'd2, 8'hFD, ok);
      exp = sb8.pop_front();
      n_tests++;
      if (!ok || p8 !== exp) begin
         n_fail++;
         $display("FAIL after_abort: p=%h valid=%b, required %h", p8, ok, exp);
      end
      handshake8();
   endtask

   task automatic test_back_to_back();
      int acc_edges [$];
      int n_done, ecount;
      bit acc, hs;
      logic [15:0] exp;
      n_done = 0;
      ecount = 0;
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      in_valid8 = 1'b1;
      p_ready8 = 1'b1;
      while (n_done < 4 && ecount < 200) begin
         acc = in_ready8 && in_valid8;
         hs  = p_valid8 && p_ready8;
         if (acc) begin
            sb8.push_back(mul8(x8, y8));
            acc_edges.push_back(ecount);
         end
         if (hs) begin
            exp = sb8.pop_front();
            n_tests++;
            if (p8 !== exp) begin
               n_fail++;
               $display("FAIL b2b_product_%0d: p=%h, required %h", n_done, p8, exp);
            end
            n_done++;
         end
         step();
         ecount++;
         if (acc) begin
            x8 = 8'($urandom);
            y8 = 8'($urandom);
         end
      end
      in_valid8 = 1'b0;
      p_ready8 = 1'b0;
      n_tests++;
      if (n_done !== 4) begin
         n_fail++;
         $display("FAIL b2b_timeout: %0d results, required 4", n_done);
      end
      for (int i = 0; i + 1 < acc_edges.size(); i++) begin
         n_tests++;
         if (acc_edges[i+1] - acc_edges[i] !== 18) begin
            n_fail++;
            $display("FAIL b2b_period_%0d: %0d edges, required 18", i, acc_edges[i+1] - acc_edges[i]);
         end
      end
      sb8.delete();
      step();
   endtask

   task automatic test_random32();
      int waited;
      logic [63:0] exp;
      for (int r = 0; r < ROUNDS; r++) begin
         for (int l = 0; l < NL; l++) begin
            if (r == 0 && l < NCORNER) begin
               x32[l] = cx_tab[l];
               y32[l] = cy_tab[l];
            end else begin
               x32[l] = $urandom;
               y32[l] = $urandom;
            end
            sb32.push_back(mul32(x32[l], y32[l]));
         end
         in_valid32 = 1'b1;
         step();
         in_valid32 = 1'b0;
         for (int l = 0; l < NL; l++) begin
            x32[l] = ~x32[l];
            y32[l] = ~y32[l];
         end
         waited = 0;
         while (!(&p_valid32) && waited < 80) begin
            step();
            waited++;
         end
         if (!(&p_valid32)) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand32_timeout: round %0d p_valid=%h, required ffff", r, p_valid32);
            break;
         end
         for (int l = 0; l < NL; l++) begin
            exp = sb32.pop_front();
            n_tests++;
            if (p32[l] !== exp) begin
               n_fail++;
               $display("FAIL rand32_r%0d_l%0d: p=%h, required %h", r, l, p32[l], exp);
            end
         end
         p_ready32 = 1'b1;
         step();
         p_ready32 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_hold();
      test_reset_mid_run();
      test_back_to_back();
      test_random32();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
